// File: rtl/dcache_nway_pkg.sv
// dcache_nway_pkg: shared word type, FSM encodings and address-field width helpers for dcache_nway.
package dcache_nway_pkg;
  typedef logic [31:0] word_t;
  localparam logic [31:0] HITADDR_DEF = 32'h3100;
  localparam logic [2:0] IDLE = 3'd0, WB = 3'd1, FILL = 3'd2, FLUSH = 3'd3, HITWR = 3'd4, DONE = 3'd5;
  function automatic int fieldw(input int n);
    return $clog2(n);
  endfunction
  function automatic int cntw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dcache_nway_lru.sv
// dcache_lru: true-LRU age tracker for one set; touched way becomes age 0, the oldest way is the victim.
module dcache_lru import dcache_nway_pkg::*; #(
  parameter int WAYS = 2,
  localparam int AW = cntw(WAYS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          touch_i,
  input  logic [AW-1:0] way_i,
  output logic [AW-1:0] victim_o
);
  logic [AW-1:0] age_q [WAYS];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= AW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++)
        age_q[w] <= AW'(w) == way_i ? '0 : age_q[w] < age_q[way_i] ? age_q[w] + 1'b1 : age_q[w];
    end
  end
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) if (age_q[w] == AW'(WAYS - 1)) victim_o = AW'(w);
  end
endmodule

// File: rtl/dcache_nway.sv
// dcache_nway: N-way write-back/write-allocate data cache with true-LRU and dirty flush on halt.
// Define DCACHE_HITCNT_EN to count hits and store the count to HITADDR after the flush.
module dcache_nway import dcache_nway_pkg::*; #(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  parameter int BLKWORDS = 2,
  parameter logic [31:0] HITADDR = HITADDR_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int OFFW = fieldw(BLKWORDS);
  localparam int IDXW = fieldw(SETS);
  localparam int TAGW = 30 - OFFW - IDXW;
  localparam int BW = cntw(BLKWORDS);
  localparam int WW = cntw(WAYS);
`ifdef DCACHE_HITCNT_EN
  localparam logic [2:0] FLUSH_END = HITWR;
`else
  localparam logic [2:0] FLUSH_END = DONE;
`endif
  logic [2:0] state_q, state_d;
  logic [BW-1:0] beat_q, beat_d, off;
  logic [WW-1:0] vway_q, vway_d, fway_q, fway_d, hway, iway, lway;
  logic [IDXW-1:0] fset_q, fset_d, idx, lset;
  logic [TAGW-1:0] tag;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [TAGW-1:0] tag_q [WAYS][SETS];
  word_t data_q [WAYS][SETS][BLKWORDS];
  logic [WW-1:0] lru_vic [SETS];
  logic req, wr, hit, inv, last;
  word_t wb_addr, fill_addr;
  assign req = dmemREN | dmemWEN;
  assign wr = dmemWEN & ~dmemREN;
  assign idx = IDXW'(dmemaddr >> (2 + OFFW));
  assign off = BW'((dmemaddr >> 2) & 32'(BLKWORDS - 1));
  assign tag = TAGW'(dmemaddr >> (2 + OFFW + IDXW));
  // WB and FLUSH share the writeback datapath; only the line selector differs
  assign lset = state_q == FLUSH ? fset_q : idx;
  assign lway = state_q == FLUSH ? fway_q : vway_q;
  assign last = beat_q == BW'(BLKWORDS - 1);
  assign wb_addr = 32'(tag_q[lway][lset]) << (2 + OFFW + IDXW) | 32'(lset) << (2 + OFFW) | 32'(beat_q) << 2;
  assign fill_addr = (dmemaddr & ~32'(BLKWORDS * 4 - 1)) | 32'(beat_q) << 2;
  assign dhit = state_q == IDLE && req && hit;
  assign dmemload = dhit ? data_q[hway][idx][off] : '0;
  assign flushed = state_q == DONE;
  always_comb begin
    hit = 1'b0;
    hway = '0;
    inv = 1'b0;
    iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit = 1'b1;
        hway = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv = 1'b1;
        iway = WW'(w);
      end
    end
  end
  for (genvar s = 0; s < SETS; s++) begin : g_lru
    dcache_lru #(.WAYS(WAYS)) u_lru (
      .clk_i(CLK), .rst_ni(nRST), .touch_i(dhit && idx == IDXW'(s)), .way_i(hway), .victim_o(lru_vic[s])
    );
  end
`ifdef DCACHE_HITCNT_EN
  word_t cnt_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else if (dhit) cnt_q <= cnt_q + 1'b1;
  end
`endif
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    vway_d = vway_q;
    fset_d = fset_q;
    fway_d = fway_q;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          vway_d = inv ? iway : lru_vic[idx];
          beat_d = '0;
          state_d = dirty_q[idx][vway_d] ? WB : FILL;
        end else if (!req && halt) begin
          state_d = FLUSH;
          fset_d = '0;
          fway_d = '0;
          beat_d = '0;
        end
      end
      WB: begin
        dWEN = 1'b1;
        daddr = wb_addr;
        dstore = data_q[lway][lset][beat_q];
        if (!dwait) begin
          beat_d = last ? '0 : beat_q + 1'b1;
          state_d = last ? FILL : WB;
        end
      end
      FILL: begin
        dREN = 1'b1;
        daddr = fill_addr;
        if (!dwait) begin
          beat_d = last ? '0 : beat_q + 1'b1;
          state_d = last ? IDLE : FILL;
        end
      end
      FLUSH: begin
        if (dirty_q[fset_q][fway_q]) begin
          dWEN = 1'b1;
          daddr = wb_addr;
          dstore = data_q[lway][lset][beat_q];
          if (!dwait) beat_d = last ? '0 : beat_q + 1'b1;
        end
        if (!dirty_q[fset_q][fway_q] || (!dwait && last)) begin
          fway_d = fway_q == WW'(WAYS - 1) ? '0 : fway_q + 1'b1;
          if (fway_q == WW'(WAYS - 1)) begin
            fset_d = fset_q + 1'b1;
            if (fset_q == IDXW'(SETS - 1)) state_d = FLUSH_END;
          end
        end
      end
`ifdef DCACHE_HITCNT_EN
      HITWR: begin
        dWEN = 1'b1;
        daddr = HITADDR;
        dstore = cnt_q;
        if (!dwait) state_d = DONE;
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      beat_q <= '0;
      vway_q <= '0;
      fset_q <= '0;
      fway_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      vway_q <= vway_d;
      fset_q <= fset_d;
      fway_q <= fway_d;
      if (dhit && wr) dirty_q[idx][hway] <= 1'b1;
      if ((state_q == WB || state_q == FLUSH) && dWEN && !dwait && last) dirty_q[lset][lway] <= 1'b0;
      if (state_q == FILL && !dwait && last) begin
        valid_q[idx][vway_q] <= 1'b1;
        dirty_q[idx][vway_q] <= 1'b0;
      end
      if (state_q == DONE) for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (dhit && wr) data_q[hway][idx][off] <= dmemstore;
    if (state_q == FILL && !dwait) data_q[vway_q][idx][beat_q] <= dload;
    if (state_q == FILL && !dwait && last) tag_q[vway_q][idx] <= tag;
  end
endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway: directed checks of dcache_nway fills, LRU eviction, wait stalls, flush and reset abort.
module tb_dcache_nway;
  logic CLK = 1'b0, nRST = 1'b0;
  always #5 CLK = ~CLK;
  int total = 0, bad = 0;
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  logic ren0 = 0, wen0 = 0, halt0 = 0, dwait0 = 0;
  logic [31:0] addr0 = 0, store0 = 0;
  logic dhit0, flushed0, dREN0, dWEN0;
  logic [31:0] load0, daddr0, dstore0, dload0;
  logic ren1 = 0, wen1 = 0, halt1 = 0, dwait1 = 0;
  logic [31:0] addr1 = 0, store1 = 0;
  logic dhit1, flushed1, dREN1, dWEN1;
  logic [31:0] load1, daddr1, dstore1, dload1;
  assign dload0 = pat(daddr0);
  assign dload1 = pat(daddr1);
  dcache_nway u0 (
    .CLK(CLK), .nRST(nRST), .dmemREN(ren0), .dmemWEN(wen0), .dmemaddr(addr0), .dmemstore(store0),
    .halt(halt0), .dhit(dhit0), .dmemload(load0), .flushed(flushed0), .dREN(dREN0), .dWEN(dWEN0),
    .daddr(daddr0), .dstore(dstore0), .dload(dload0), .dwait(dwait0)
  );
  dcache_nway #(.WAYS(4), .SETS(4), .BLKWORDS(4)) u1 (
    .CLK(CLK), .nRST(nRST), .dmemREN(ren1), .dmemWEN(wen1), .dmemaddr(addr1), .dmemstore(store1),
    .halt(halt1), .dhit(dhit1), .dmemload(load1), .flushed(flushed1), .dREN(dREN1), .dWEN(dWEN1),
    .daddr(daddr1), .dstore(dstore1), .dload(dload1), .dwait(dwait1)
  );
  logic [31:0] rlog0[$], wa0[$], wd0[$], rlog1[$];
  always @(posedge CLK) begin
    if (dREN0 && !dwait0) rlog0.push_back(daddr0);
    if (dWEN0 && !dwait0) begin
      wa0.push_back(daddr0);
      wd0.push_back(dstore0);
    end
    if (dREN1 && !dwait1) rlog1.push_back(daddr1);
  end

  task automatic acc0(input logic wr, input logic [31:0] a, d, output logic [31:0] rd, output int cyc);
    cyc = 0;
    ren0 = !wr; wen0 = wr; addr0 = a; store0 = d;
    #1;
    while (!dhit0 && cyc < 100) begin
      @(posedge CLK); #1; cyc++;
    end
    rd = load0;
    total++;
    if (cyc >= 100) begin bad++; $display("FAIL acc0_timeout addr=%h got no dhit want dhit", a); end
    @(posedge CLK); #1;
    ren0 = 0; wen0 = 0;
  endtask

  task automatic acc1(input logic [31:0] a, output logic [31:0] rd, output int cyc);
    cyc = 0;
    ren1 = 1; addr1 = a;
    #1;
    while (!dhit1 && cyc < 100) begin
      @(posedge CLK); #1; cyc++;
    end
    rd = load1;
    total++;
    if (cyc >= 100) begin bad++; $display("FAIL acc1_timeout addr=%h got no dhit want dhit", a); end
    @(posedge CLK); #1;
    ren1 = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({dhit0, dREN0, dWEN0, flushed0} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {dhit0, dREN0, dWEN0, flushed0}); end
    total++;
    if ({daddr0, dstore0, load0} !== 96'b0) begin bad++; $display("FAIL reset_buses got=%h want=0", {daddr0, dstore0, load0}); end
    nRST = 1;
    @(posedge CLK); #1;
    total++;
    if ({dhit0, dREN0, dWEN0, dhit1, dREN1} !== 5'b0) begin bad++; $display("FAIL idle_after_reset got=%b want=00000", {dhit0, dREN0, dWEN0, dhit1, dREN1}); end
  endtask

  task automatic test_cold_read;
    logic [31:0] rd;
    int cyc;
    acc0(0, 32'h40, 0, rd, cyc);
    total++;
    if (cyc !== 3) begin bad++; $display("FAIL cold_cycles got=%0d want=3", cyc); end
    total++;
    if (rlog0.size() !== 2 || rlog0[0] !== 32'h40 || rlog0[1] !== 32'h44) begin bad++; $display("FAIL cold_fill_addrs got=%p want=40,44", rlog0); end
    total++;
    if (rd !== pat(32'h40)) begin bad++; $display("FAIL cold_data got=%h want=%h", rd, pat(32'h40)); end
    acc0(0, 32'h44, 0, rd, cyc);
    total++;
    if (cyc !== 0 || rlog0.size() !== 2) begin bad++; $display("FAIL reread_hit got cyc=%0d reads=%0d want 0,2", cyc, rlog0.size()); end
    total++;
    if (rd !== pat(32'h44)) begin bad++; $display("FAIL reread_data got=%h want=%h", rd, pat(32'h44)); end
  endtask

  task automatic test_lru_wb_stall;
    logic [31:0] rd;
    int cyc;
    acc0(1, 32'h40, 32'hDEADBEEF, rd, cyc);
    total++;
    if (cyc !== 0) begin bad++; $display("FAIL write_hit_cycles got=%0d want=0", cyc); end
    acc0(0, 32'h80, 0, rd, cyc);
    total++;
    if (rd !== pat(32'h80) || wa0.size() !== 0) begin bad++; $display("FAIL miss80 got=%h writes=%0d want=%h,0", rd, wa0.size(), pat(32'h80)); end
    acc0(0, 32'h40, 0, rd, cyc);
    total++;
    if (rd !== 32'hDEADBEEF || cyc !== 0) begin bad++; $display("FAIL write_readback got=%h cyc=%0d want=deadbeef,0", rd, cyc); end
    acc0(0, 32'hC0, 0, rd, cyc);
    total++;
    if (wa0.size() !== 0 || rd !== pat(32'hC0)) begin bad++; $display("FAIL lru_clean_evict got writes=%0d data=%h want 0,%h", wa0.size(), rd, pat(32'hC0)); end
    rlog0.delete();
    fork
      acc0(0, 32'h100, 0, rd, cyc);
      begin
        int n = 0;
        while (!(dWEN0 && daddr0 == 32'h44) && n < 100) begin
          @(posedge CLK); #1; n++;
        end
        dwait0 = 1;
        for (int i = 0; i < 5; i++) begin
          @(posedge CLK); #1;
          total++;
          if (!dWEN0 || daddr0 !== 32'h44 || dstore0 !== pat(32'h44)) begin
            bad++; $display("FAIL stall_hold cycle=%0d got wen=%b addr=%h data=%h want 1,44,%h", i, dWEN0, daddr0, dstore0, pat(32'h44));
          end
        end
        dwait0 = 0;
      end
    join
    total++;
    if (cyc !== 10) begin bad++; $display("FAIL wb_fill_cycles got=%0d want=10", cyc); end
    total++;
    if (wa0.size() !== 2) begin bad++; $display("FAIL wb_count got=%0d want=2", wa0.size()); end
    else begin
      total++;
      if (wa0[0] !== 32'h40 || wd0[0] !== 32'hDEADBEEF || wa0[1] !== 32'h44 || wd0[1] !== pat(32'h44)) begin
        bad++; $display("FAIL wb_beats got=%h:%h %h:%h want 40:deadbeef 44:%h", wa0[0], wd0[0], wa0[1], wd0[1], pat(32'h44));
      end
    end
    total++;
    if (rlog0.size() !== 2 || rlog0[0] !== 32'h100 || rlog0[1] !== 32'h104 || rd !== pat(32'h100)) begin
      bad++; $display("FAIL fill_after_wb got=%p data=%h want 100,104 data=%h", rlog0, rd, pat(32'h100));
    end
  endtask

  task automatic test_lru4;
    logic [31:0] rd;
    int cyc;
    acc1(32'h000, rd, cyc);
    total++;
    if (cyc !== 5 || rd !== pat(32'h0)) begin bad++; $display("FAIL w4_cold got cyc=%0d data=%h want 5,%h", cyc, rd, pat(32'h0)); end
    acc1(32'h040, rd, cyc);
    acc1(32'h080, rd, cyc);
    acc1(32'h0C0, rd, cyc);
    acc1(32'h000, rd, cyc);
    total++;
    if (cyc !== 0) begin bad++; $display("FAIL w4_touch0 got cyc=%0d want=0", cyc); end
    rlog1.delete();
    acc1(32'h100, rd, cyc);
    total++;
    if (rlog1.size() !== 4 || rlog1[0] !== 32'h100 || rlog1[1] !== 32'h104 || rlog1[2] !== 32'h108 || rlog1[3] !== 32'h10C) begin
      bad++; $display("FAIL w4_fill_beats got=%p want 100,104,108,10c", rlog1);
    end
    acc1(32'h000, rd, cyc);
    total++;
    if (cyc !== 0) begin bad++; $display("FAIL w4_keep_way0 got cyc=%0d want=0", cyc); end
    acc1(32'h088, rd, cyc);
    total++;
    if (cyc !== 0 || rd !== pat(32'h88)) begin bad++; $display("FAIL w4_keep_way2 got cyc=%0d data=%h want 0,%h", cyc, rd, pat(32'h88)); end
    acc1(32'h0CC, rd, cyc);
    total++;
    if (cyc !== 0) begin bad++; $display("FAIL w4_keep_way3 got cyc=%0d want=0", cyc); end
    acc1(32'h040, rd, cyc);
    total++;
    if (cyc !== 5) begin bad++; $display("FAIL w4_way1_evicted got cyc=%0d want=5", cyc); end
  endtask

  task automatic test_flush;
    logic [31:0] rd;
    int cyc, n;
    logic [31:0] ea [6];
    logic [31:0] ed [6];
    ea = '{32'h100, 32'h104, 32'hC0, 32'hC4, 32'h48, 32'h4C};
    ed = '{pat(32'h100), 32'h11111111, 32'h22222222, pat(32'hC4), pat(32'h48), 32'h33333333};
    acc0(1, 32'h104, 32'h11111111, rd, cyc);
    acc0(1, 32'hC0, 32'h22222222, rd, cyc);
    total++;
    if (cyc !== 0) begin bad++; $display("FAIL flush_prep_hit got cyc=%0d want=0", cyc); end
    acc0(1, 32'h4C, 32'h33333333, rd, cyc);
    wa0.delete(); wd0.delete();
    halt0 = 1;
    n = 0;
    while (!flushed0 && n < 300) begin
      @(posedge CLK); #1; n++;
    end
    total++;
    if (!flushed0) begin bad++; $display("FAIL flush_done got flushed=0 want=1"); end
`ifdef DCACHE_HITCNT_EN
    total++;
    if (wa0.size() !== 7) begin bad++; $display("FAIL flush_writes got=%0d want=7", wa0.size()); end
    else begin
      total++;
      if (wa0[6] !== 32'h3100 || wd0[6] !== 32'd10) begin bad++; $display("FAIL hitcnt_write got=%h:%0d want 3100:10", wa0[6], wd0[6]); end
    end
`else
    total++;
    if (wa0.size() !== 6) begin bad++; $display("FAIL flush_writes got=%0d want=6", wa0.size()); end
`endif
    for (int i = 0; i < 6 && i < wa0.size(); i++) begin
      total++;
      if (wa0[i] !== ea[i] || wd0[i] !== ed[i]) begin bad++; $display("FAIL flush_beat%0d got=%h:%h want %h:%h", i, wa0[i], wd0[i], ea[i], ed[i]); end
    end
    halt0 = 0;
    ren0 = 1; addr0 = 32'h100;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (dhit0 || dREN0 || !flushed0) begin bad++; $display("FAIL done_holds got hit=%b ren=%b flushed=%b want 0,0,1", dhit0, dREN0, flushed0); end
    ren0 = 0;
  endtask

  task automatic test_reset_mid_fill;
    logic [31:0] rd;
    int cyc, n;
    nRST = 0;
    @(posedge CLK); #1;
    nRST = 1;
    @(posedge CLK); #1;
    total++;
    if (flushed0) begin bad++; $display("FAIL flushed_clear got=1 want=0"); end
    ren0 = 1; addr0 = 32'h40;
    n = 0;
    while (!(dREN0 && daddr0 == 32'h44) && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    nRST = 0;
    #1;
    total++;
    if (dREN0 || daddr0 !== 32'h0) begin bad++; $display("FAIL abort_fill got ren=%b addr=%h want 0,0", dREN0, daddr0); end
    @(posedge CLK); #1;
    nRST = 1; ren0 = 0;
    @(posedge CLK); #1;
    rlog0.delete();
    acc0(0, 32'h40, 0, rd, cyc);
    total++;
    if (cyc !== 3 || rlog0.size() !== 2 || rd !== pat(32'h40)) begin
      bad++; $display("FAIL remiss got cyc=%0d reads=%0d data=%h want 3,2,%h", cyc, rlog0.size(), rd, pat(32'h40));
    end
  endtask

  initial begin
    test_reset;
    test_cold_read;
    test_lru_wb_stall;
    test_lru4;
    test_flush;
    test_reset_mid_fill;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
